// File: rtl/left_rotate_seq_if.sv
// Handshake bundle for the sequential left rotator: request side (data + amount)
// and response side (rotated word), each with its own valid/ready pair.
interface left_rotate_seq_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned AMT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output in_data, in_amt, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  in_data, in_amt, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/left_rotate_seq.sv
// Multi-cycle left rotator: resolves one rotate-amount bit per cycle, MSB first,
// and holds the result until the consumer takes it. Inverse of the ALU right rotator.
module left_rotate_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  left_rotate_seq_if.slave  bus
);
  localparam int unsigned AMT_W   = $clog2(WIDTH);
  localparam int unsigned STAGE_W = $clog2(AMT_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state;
  logic [STAGE_W-1:0] stage;
  logic [WIDTH-1:0]   data_reg;
  logic [AMT_W-1:0]   amt_reg;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  // Rotate left by taking the upper half of the doubled word shifted left.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] d,
                                            input logic [AMT_W-1:0] sh);
    logic [2*WIDTH-1:0] t;
    t = {d, d} << sh;
    return t[2*WIDTH-1:WIDTH];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      stage       <= '0;
      data_reg    <= '0;
      amt_reg     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_reg   <= bus.in_data;
            amt_reg    <= bus.in_amt;
            stage      <= STAGE_W'(AMT_W - 1);
            state      <= ROTATE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ROTATE: begin
          if (amt_reg[stage]) begin
            data_reg <= rotl(data_reg, AMT_W'(1) << stage);
          end
          // Full stage count regardless of amount; no early exit.
          if (stage == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            stage <= stage - STAGE_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          stage       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = data_reg;
endmodule

// File: tb/tb_left_rotate_seq.sv
// Scoreboard bench for left_rotate_seq: driver pushes expected words, a negedge
// monitor pops and compares on every output handshake.
module tb_left_rotate_seq;
  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   cyc;
  logic [31:0] exp_q[$];

  left_rotate_seq_if #(.WIDTH(32)) bus ();

  left_rotate_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU right rotator.
  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] k);
    logic [63:0] t;
    t = {x, x} >> k;
    return t[31:0];
  endfunction

  // Monitor: compare on each output handshake.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected no output", bus.out_data);
      end else begin
        chk("out_data", bus.out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  // One operation with out_ready high; reports latency and busy-high cycles.
  task automatic run_op(input logic [31:0] d, input logic [4:0] a, input logic [31:0] e,
                        output int lat, output int bcyc, output int acc_cyc);
    int c = 0;
    wait_ready();
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_valid = 1'b1;
    exp_q.push_back(e);
    tick();
    acc_cyc      = cyc - 1;
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_amt   = 5'($urandom);
    lat  = -1;
    bcyc = 0;
    while (bus.busy && c < 40) begin
      if (bus.out_valid && lat < 0) lat = c;
      bcyc++;
      tick();
      c++;
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic [4:0]  a;
    logic [31:0] e;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int lat, bcyc, acc0, acc1, acc2;
    errors = 0;
    checks = 0;
    cyc    = 0;
    reset  = 1'b1;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_data", bus.out_data, 32'h0);
    reset = 1'b0;
    tick();

    // Directed rotates with hand-computed results.
    vecs[0] = '{32'h80000001, 5'd1,  32'h00000003};
    vecs[1] = '{32'h12345678, 5'd8,  32'h34567812};
    vecs[2] = '{32'h00000001, 5'd31, 32'h80000000};
    vecs[3] = '{32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    foreach (vecs[i]) begin
      run_op(vecs[i].d, vecs[i].a, vecs[i].e, lat, bcyc, acc0);
      chk($sformatf("latency_%0d", i), 32'(lat), 32'd5);
      chk($sformatf("busy_cycles_%0d", i), 32'(bcyc), 32'd6);
    end

    // Backpressure: hold out_ready low for 10 cycles, offer a word that must be ignored.
    bus.out_ready = 1'b0;
    wait_ready();
    bus.in_data  = 32'hF0000000;
    bus.in_amt   = 5'd4;
    bus.in_valid = 1'b1;
    exp_q.push_back(32'h0000000F);
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    chk("bp_valid_rise", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i >= 3 && i <= 6) begin
        bus.in_data  = 32'h11111111;
        bus.in_amt   = 5'd3;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      chk("bp_out_data", bus.out_data, 32'h0000000F);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    run_op(32'h00000F00, 5'd20, 32'hF0000000, lat, bcyc, acc0);
    chk("bp_second_latency", 32'(lat), 32'd5);

    // Back-to-back: accepts 7 cycles apart, results in order.
    run_op(32'hCAFEBABE, 5'd16, 32'hBABECAFE, lat, bcyc, acc0);
    run_op(32'h00000003, 5'd30, 32'hC0000000, lat, bcyc, acc1);
    run_op(32'h0F0F0F0F, 5'd12, 32'hF0F0F0F0, lat, bcyc, acc2);
    chk("b2b_gap_1", 32'(acc1 - acc0), 32'd7);
    chk("b2b_gap_2", 32'(acc2 - acc1), 32'd7);

    // Reset at E3 of an amt=31 operation; no output expected from it.
    wait_ready();
    bus.in_data  = 32'h00000001;
    bus.in_amt   = 5'd31;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data", bus.out_data, 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    run_op(32'hA5A5A5A5, 5'd4, 32'h5A5A5A5A, lat, bcyc, acc0);
    chk("postrst_latency", 32'(lat), 32'd5);

    // Round trip through the right rotator: exhaustive k with x=1, then random.
    for (int k = 0; k < 32; k++) begin
      run_op(rotr(32'h00000001, 5'(k)), 5'(k), 32'h00000001, lat, bcyc, acc0);
    end
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] x;
      logic [4:0]  k;
      x = $urandom;
      k = 5'($urandom_range(0, 31));
      run_op(rotr(x, k), k, x, lat, bcyc, acc0);
    end

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
